// File: rtl/iob_cache_be_ram_lat.sv
// Back-end RAM model for cache verification: byte-strobed writes, fixed read
// latency, optional periodic ready stalls and saturating access counters.
module iob_cache_be_ram_lat #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned MEM_ADDR_W   = 10,
  parameter int unsigned READ_LAT     = 2,
  parameter int unsigned STALL_PERIOD = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              iob_valid_i,
  input  logic [ADDR_W-1:0] iob_addr_i,
  input  logic [DATA_W-1:0] iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic [DATA_W-1:0] iob_rdata_o,
  output logic              iob_rvalid_o,
  output logic              iob_ready_o,
  output logic [CNT_W-1:0]  nrd_o,
  output logic [CNT_W-1:0]  nwr_o
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned NB_W    = $clog2(STRB_W);
  localparam int unsigned LAT_W   = 4;
  localparam int unsigned STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_nxt;
  logic [LAT_W-1:0]    lat_cnt, lat_cnt_nxt;
  logic [DATA_W-1:0]   rd_buf, rd_buf_nxt, rdata_nxt;
  logic                rvalid_nxt;
  logic [CNT_W-1:0]    nrd_nxt, nwr_nxt;
  logic [DATA_W-1:0]   mem [2**MEM_ADDR_W];
  logic [MEM_ADDR_W-1:0] idx;
  logic                stall, accept, is_wr;
  logic                unused_addr;

  // Upper address bits alias; byte-offset bits only select within a word.
  assign idx         = iob_addr_i[NB_W+MEM_ADDR_W-1:NB_W];
  assign unused_addr = ^iob_addr_i;
  assign is_wr       = |iob_wstrb_i;
  assign accept      = iob_valid_i & iob_ready_o & cke_i;
  assign iob_ready_o = (state == IDLE) && !stall;

  generate
    if (STALL_PERIOD > 0) begin : g_stall
      logic [STALL_W-1:0] stall_cnt;
      always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) stall_cnt <= '0;
        else if (cke_i)
          stall_cnt <= (stall_cnt == STALL_W'(STALL_PERIOD - 1)) ? '0 : stall_cnt + STALL_W'(1);
      end
      assign stall = (stall_cnt == STALL_W'(STALL_PERIOD - 1));
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk_i) begin
    if (accept && is_wr) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (iob_wstrb_i[b]) mem[idx][b*8 +: 8] <= iob_wdata_i[b*8 +: 8];
      end
    end
  end

  // Read data is sampled at acceptance and released when the latency expires.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    rd_buf_nxt  = rd_buf;
    rvalid_nxt  = 1'b0;
    rdata_nxt   = iob_rdata_o;
    nrd_nxt     = nrd_o;
    nwr_nxt     = nwr_o;
    case (state)
      IDLE: begin
        if (accept && !is_wr) begin
          if (READ_LAT == 1) begin
            rvalid_nxt = 1'b1;
            rdata_nxt  = mem[idx];
          end else begin
            state_nxt   = BUSY;
            lat_cnt_nxt = LAT_W'(READ_LAT - 1);
            rd_buf_nxt  = mem[idx];
          end
        end
      end
      BUSY: begin
        if (lat_cnt == LAT_W'(1)) begin
          state_nxt   = IDLE;
          lat_cnt_nxt = '0;
          rvalid_nxt  = 1'b1;
          rdata_nxt   = rd_buf;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept && is_wr && (nwr_o != '1))  nwr_nxt = nwr_o + CNT_W'(1);
    if (accept && !is_wr && (nrd_o != '1)) nrd_nxt = nrd_o + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      rd_buf       <= '0;
      iob_rvalid_o <= 1'b0;
      iob_rdata_o  <= '0;
      nrd_o        <= '0;
      nwr_o        <= '0;
    end else if (cke_i) begin
      state        <= state_nxt;
      lat_cnt      <= lat_cnt_nxt;
      rd_buf       <= rd_buf_nxt;
      iob_rvalid_o <= rvalid_nxt;
      iob_rdata_o  <= rdata_nxt;
      nrd_o        <= nrd_nxt;
      nwr_o        <= nwr_nxt;
    end
  end

endmodule

// File: tb/tb_iob_cache_be_ram_lat.sv
// Directed bench for iob_cache_be_ram_lat: four instances cover latency 2,
// latency 1, periodic stalls and reset during an in-flight read.
module tb_iob_cache_be_ram_lat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic cke_on = 1'b1;

  // a: READ_LAT=2 ; b: READ_LAT=1 ; c: STALL_PERIOD=4 ; d: READ_LAT=4
  logic a_rst, a_cke, a_valid, a_rvalid, a_ready;
  logic [23:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic [15:0] a_nrd, a_nwr;
  logic b_rst, b_valid, b_rvalid, b_ready;
  logic [23:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_wstrb;
  logic [15:0] b_nrd, b_nwr;
  logic c_rst, c_valid, c_rvalid, c_ready;
  logic [23:0] c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic [3:0]  c_wstrb;
  logic [15:0] c_nrd, c_nwr;
  logic d_rst, d_valid, d_rvalid, d_ready;
  logic [23:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic [15:0] d_nrd, d_nwr;

  iob_cache_be_ram_lat #(.READ_LAT(2)) u_a (
    .clk_i(clk), .cke_i(a_cke), .arst_i(a_rst), .iob_valid_i(a_valid), .iob_addr_i(a_addr),
    .iob_wdata_i(a_wdata), .iob_wstrb_i(a_wstrb), .iob_rdata_o(a_rdata), .iob_rvalid_o(a_rvalid),
    .iob_ready_o(a_ready), .nrd_o(a_nrd), .nwr_o(a_nwr));
  iob_cache_be_ram_lat #(.READ_LAT(1)) u_b (
    .clk_i(clk), .cke_i(cke_on), .arst_i(b_rst), .iob_valid_i(b_valid), .iob_addr_i(b_addr),
    .iob_wdata_i(b_wdata), .iob_wstrb_i(b_wstrb), .iob_rdata_o(b_rdata), .iob_rvalid_o(b_rvalid),
    .iob_ready_o(b_ready), .nrd_o(b_nrd), .nwr_o(b_nwr));
  iob_cache_be_ram_lat #(.READ_LAT(2), .STALL_PERIOD(4)) u_c (
    .clk_i(clk), .cke_i(cke_on), .arst_i(c_rst), .iob_valid_i(c_valid), .iob_addr_i(c_addr),
    .iob_wdata_i(c_wdata), .iob_wstrb_i(c_wstrb), .iob_rdata_o(c_rdata), .iob_rvalid_o(c_rvalid),
    .iob_ready_o(c_ready), .nrd_o(c_nrd), .nwr_o(c_nwr));
  iob_cache_be_ram_lat #(.READ_LAT(4)) u_d (
    .clk_i(clk), .cke_i(cke_on), .arst_i(d_rst), .iob_valid_i(d_valid), .iob_addr_i(d_addr),
    .iob_wdata_i(d_wdata), .iob_wstrb_i(d_wstrb), .iob_rdata_o(d_rdata), .iob_rvalid_o(d_rvalid),
    .iob_ready_o(d_ready), .nrd_o(d_nrd), .nwr_o(d_nwr));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic v, input logic [23:0] ad, input logic [31:0] wd, input logic [3:0] ws);
    a_valid = v; a_addr = ad; a_wdata = wd; a_wstrb = ws;
  endtask
  task automatic drv_b(input logic v, input logic [23:0] ad, input logic [31:0] wd, input logic [3:0] ws);
    b_valid = v; b_addr = ad; b_wdata = wd; b_wstrb = ws;
  endtask
  task automatic drv_c(input logic v, input logic [23:0] ad, input logic [31:0] wd, input logic [3:0] ws);
    c_valid = v; c_addr = ad; c_wdata = wd; c_wstrb = ws;
  endtask
  task automatic drv_d(input logic v, input logic [23:0] ad, input logic [31:0] wd, input logic [3:0] ws);
    d_valid = v; d_addr = ad; d_wdata = wd; d_wstrb = ws;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1; d_rst = 1'b1; a_cke = 1'b1;
    drv_a(1'b0, 24'h0, 32'h0, 4'h0);
    drv_b(1'b0, 24'h0, 32'h0, 4'h0);
    drv_c(1'b0, 24'h0, 32'h0, 4'h0);
    drv_d(1'b0, 24'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    check("rst_rvalid", 64'(a_rvalid), 64'd0);
    check("rst_rdata", 64'(a_rdata), 64'd0);
    check("rst_nrd", 64'(a_nrd), 64'd0);
    check("rst_nwr", 64'(a_nwr), 64'd0);
    check("rst_ready", 64'(a_ready), 64'd1);

    // Write then read with latency 2.
    a_rst = 1'b0; b_rst = 1'b0;
    check("a_ready_after_rst", 64'(a_ready), 64'd1);
    drv_a(1'b1, 24'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("a_nwr_after_write", 64'(a_nwr), 64'd1);
    drv_a(1'b1, 24'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("a_ready_busy", 64'(a_ready), 64'd0);
    check("a_rvalid_early", 64'(a_rvalid), 64'd0);
    drv_a(1'b0, 24'h10, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    check("a_rvalid", 64'(a_rvalid), 64'd1);
    check("a_rdata_deadbeef", 64'(a_rdata), 64'hDEADBEEF);
    check("a_ready_rvalid_cycle", 64'(a_ready), 64'd1);
    check("a_nrd_1", 64'(a_nrd), 64'd1);
    check("a_nwr_1", 64'(a_nwr), 64'd1);

    // Partial-strobe merge.
    drv_a(1'b1, 24'h20, 32'h11223344, 4'hF);
    @(negedge clk);
    check("a_rvalid_one_cycle", 64'(a_rvalid), 64'd0);
    check("a_rdata_hold", 64'(a_rdata), 64'hDEADBEEF);
    drv_a(1'b1, 24'h20, 32'hAABBCCDD, 4'h5);
    @(negedge clk);
    drv_a(1'b1, 24'h20, 32'h0, 4'h0);
    @(negedge clk);
    drv_a(1'b0, 24'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("a_rvalid_merge", 64'(a_rvalid), 64'd1);
    check("a_rdata_merge", 64'(a_rdata), 64'h11BB33DD);
    check("a_nwr_3", 64'(a_nwr), 64'd3);
    check("a_nrd_2", 64'(a_nrd), 64'd2);

    // Aliasing read, with the clock enable dropped while busy.
    drv_a(1'b1, 24'h0, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    drv_a(1'b1, 24'h1000, 32'h0, 4'h0);
    @(negedge clk);
    drv_a(1'b0, 24'h0, 32'h0, 4'h0);
    a_cke = 1'b0;
    @(negedge clk);
    check("a_ready_frozen", 64'(a_ready), 64'd0);
    check("a_rvalid_frozen", 64'(a_rvalid), 64'd0);
    @(negedge clk);
    a_cke = 1'b1;
    check("a_rvalid_before_resume", 64'(a_rvalid), 64'd0);
    @(negedge clk);
    check("a_rvalid_alias", 64'(a_rvalid), 64'd1);
    check("a_rdata_alias", 64'(a_rdata), 64'hCAFEF00D);
    check("a_nrd_3", 64'(a_nrd), 64'd3);
    check("a_nwr_4", 64'(a_nwr), 64'd4);

    // Latency 1: back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      drv_b(1'b1, 24'(4 * i), 32'hA0 + 32'(i), 4'hF);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check("b_ready", 64'(b_ready), 64'd1);
      if (i > 0) begin
        check("b_rvalid", 64'(b_rvalid), 64'd1);
        check("b_rdata", 64'(b_rdata), 64'hA0 + 64'(i - 1));
      end
      if (i < 4) drv_b(1'b1, 24'(4 * i), 32'h0, 4'h0);
      else       drv_b(1'b0, 24'h0, 32'h0, 4'h0);
      @(negedge clk);
    end
    check("b_rvalid_end", 64'(b_rvalid), 64'd0);
    check("b_nrd_4", 64'(b_nrd), 64'd4);
    check("b_nwr_4", 64'(b_nwr), 64'd4);

    // Periodic stall: ready drops every fourth cycle after reset.
    c_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("c_ready", 64'(c_ready), 64'((i % 4) != 3));
      drv_c(1'b1, 24'(4 * i), 32'(i), 4'hF);
      @(negedge clk);
    end
    drv_c(1'b0, 24'h0, 32'h0, 4'h0);
    check("c_nwr_12", 64'(c_nwr), 64'd12);
    check("c_nrd_0", 64'(c_nrd), 64'd0);
    check("c_rvalid_0", 64'(c_rvalid), 64'd0);
    check("c_rdata_0", 64'(c_rdata), 64'd0);

    // Reset while a latency-4 read is in flight.
    d_rst = 1'b0;
    check("d_ready_after_rst", 64'(d_ready), 64'd1);
    drv_d(1'b1, 24'h0, 32'h55, 4'hF);
    @(negedge clk);
    drv_d(1'b1, 24'h0, 32'h0, 4'h0);
    @(negedge clk);
    drv_d(1'b0, 24'h0, 32'h0, 4'h0);
    check("d_ready_busy", 64'(d_ready), 64'd0);
    @(negedge clk);
    d_rst = 1'b1;
    #1;
    check("d_ready_in_rst", 64'(d_ready), 64'd1);
    check("d_nrd_in_rst", 64'(d_nrd), 64'd0);
    @(negedge clk);
    d_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("d_rvalid_discarded", 64'(d_rvalid), 64'd0);
      check("d_ready_idle", 64'(d_ready), 64'd1);
      @(negedge clk);
    end
    check("d_nrd_0", 64'(d_nrd), 64'd0);
    check("d_nwr_0", 64'(d_nwr), 64'd0);
    check("d_rdata_0", 64'(d_rdata), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
